// File: rtl/alu_pkg.sv
// Shared types for the tinyalu front-end arbiter.
//   operand_t  : 8-bit ALU operand
//   result_t   : 16-bit ALU result
//   opcode_t   : tinyalu opcode encoding
//   arb_state_t: arbiter sequencing states
package alu_pkg;

  typedef logic [7:0]  operand_t;
  typedef logic [15:0] result_t;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ADD = 3'd1,
    SUB = 3'd2,
    NOT = 3'd3,
    XOR = 3'd4,
    AND = 3'd5,
    MUL = 3'd6,
    INC = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// rr_picker: combinational round-robin select.
// Searches upward from last_i+1 (with wrap) for the first set request bit.
// Ports:
//   req_i  [N_REQ]          request vector
//   last_i [$clog2(N_REQ)]  index granted most recently
//   gnt_o  [N_REQ]          one-hot grant (all zero when no request)
//   idx_o  [$clog2(N_REQ)]  index of the granted bit
//   any_o                   at least one request present
module rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] last_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o,
  output logic                     any_o
);

  localparam int IDXW = $clog2(N_REQ);

  int              sum;
  logic [IDXW-1:0] cand;
  logic            found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = 0;
    cand  = '0;
    // i runs 1..N_REQ so the last candidate is last_i itself: a lone
    // requester can be granted back-to-back.
    for (int i = 1; i <= N_REQ; i++) begin
      sum = int'(last_i) + i;
      if (sum >= N_REQ) sum = sum - N_REQ;
      cand = sum[IDXW-1:0];
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one tinyalu between N_REQ requesters, round-robin.
// One operation in flight at a time; operands are held on alu_a/alu_b/alu_op
// for the whole BUSY phase so multi-cycle ops need no special handling.
// Optional feature macro: ALU_ARB_TIMEOUT_EN (BUSY watchdog -> rsp_err).
//
// State | meaning
// IDLE  | waiting for a request (and for alu_done to clear)
// BUSY  | alu_start high, waiting for alu_done
// RESP  | response presented, waiting for rsp_ready
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req_valid/req_ready [N_REQ] per-requester handshake
//   req_a/req_b/req_op  [N_REQ] per-requester operands and opcode
//   rsp_valid/rsp_ready         response handshake
//   rsp_id, rsp_result, rsp_err response payload
//   alu_a/alu_b/alu_op/alu_start  to tinyalu
//   alu_done/alu_result           from tinyalu
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  operand_t [N_REQ-1:0]     req_a,
  input  operand_t [N_REQ-1:0]     req_b,
  input  opcode_t  [N_REQ-1:0]     req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output result_t                  rsp_result,
  output logic                     rsp_err,
  output operand_t                 alu_a,
  output operand_t                 alu_b,
  output opcode_t                  alu_op,
  output logic                     alu_start,
  input  logic                     alu_done,
  input  result_t                  alu_result
);

  localparam int IDW = $clog2(N_REQ);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] id_q, id_d;
  operand_t       a_q, a_d;
  operand_t       b_q, b_d;
  opcode_t        op_q, op_d;
  result_t        result_q, result_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  // Without the watchdog the timeout length has no effect; nothing is built.
  if (TIMEOUT_CYC < 1) begin : g_timeout_unused
  end
`endif

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    result_d  = result_q;
    req_ready = '0;
`ifdef ALU_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        // Gating with reset keeps a requester from seeing a handshake that
        // the synchronous reset is about to discard.
        if (!reset && !alu_done && pick_any) begin
          req_ready = pick_gnt;
          a_d       = req_a[pick_idx];
          b_d       = req_b[pick_idx];
          op_d      = req_op[pick_idx];
          id_d      = pick_idx;
          last_d    = pick_idx;
          state_d   = BUSY;
`ifdef ALU_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      BUSY: begin
        if (alu_done) begin
          // tinyalu leaves result undefined for NOP; answer a clean zero.
          result_d = (op_q == NOP) ? '0 : alu_result;
          state_d  = RESP;
`ifdef ALU_ARB_TIMEOUT_EN
          err_d    = 1'b0;
`endif
        end
`ifdef ALU_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= IDW'(N_REQ - 1);
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= NOP;
      result_q <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
`ifdef ALU_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign alu_start  = (state_q == BUSY);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
`ifdef ALU_ARB_TIMEOUT_EN
  assign rsp_err    = err_q;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter with a behavioural tinyalu model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  operand_t [N-1:0] req_a;
  operand_t [N-1:0] req_b;
  opcode_t  [N-1:0] req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  result_t          rsp_result;
  logic             rsp_err;
  operand_t         alu_a, alu_b;
  opcode_t          alu_op;
  logic             alu_start;
  logic             alu_done = 1'b0;
  result_t          alu_result = '0;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int mcnt = 0;
  bit stall = 1'b0;

  alu_arbiter #(.N_REQ(N), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result)
  );

  // Behavioural tinyalu: single-cycle ops finish one cycle after start,
  // MUL/INC three cycles after; NOP returns garbage.
  function automatic result_t alu_f(operand_t a, operand_t b, opcode_t op);
    case (op)
      ADD:     return {8'h00, a} + {8'h00, b};
      SUB:     return {8'h00, a} - {8'h00, b};
      NOT:     return {8'h00, ~a};
      XOR:     return {8'h00, a ^ b};
      AND:     return {8'h00, a & b};
      MUL:     return {8'h00, a} * {8'h00, b};
      INC:     return {8'h00, a} + 16'h0001;
      default: return 16'hDEAD;
    endcase
  endfunction

  function automatic int alu_lat(opcode_t op);
    return (op == MUL || op == INC) ? 3 : 1;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset || !alu_start) begin
      mcnt     <= 0;
      alu_done <= 1'b0;
    end else if (!alu_done && !stall) begin
      if (mcnt == alu_lat(alu_op) - 1) begin
        alu_done   <= 1'b1;
        alu_result <= alu_f(alu_a, alu_b, alu_op);
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_ready(int id, output int t);
    int k;
    k = 0;
    t = -1;
    while (k < 50) begin
      @(negedge clk);
      if (req_ready[id]) begin
        t = cyc;
        break;
      end
      k++;
    end
    chk($sformatf("grant_seen_req%0d", id), 32'(t >= 0), 32'd1);
  endtask

  task automatic wait_rsp(output int t);
    int k;
    k = 0;
    t = -1;
    while (k < 60) begin
      @(negedge clk);
      if (rsp_valid) begin
        t = cyc;
        break;
      end
      k++;
    end
    chk("rsp_seen", 32'(t >= 0), 32'd1);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_req(string tag, int id, operand_t a, operand_t b, opcode_t op,
                         result_t exp, logic exp_err, int lat);
    int t0, t1;
    @(posedge clk); #1;
    req_a[id] = a;
    req_b[id] = b;
    req_op[id] = op;
    req_valid[id] = 1'b1;
    wait_ready(id, t0);
    chk({tag, "_onehot"}, 32'($onehot(req_ready)), 32'd1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    wait_rsp(t1);
    chk({tag, "_id"}, 32'(rsp_id), 32'(id));
    chk({tag, "_result"}, 32'(rsp_result), 32'(exp));
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, "_latency"}, 32'(t1 - t0), 32'(lat));
  endtask

  typedef struct {
    int       id;
    operand_t a;
    operand_t b;
    opcode_t  op;
    result_t  exp;
    int       lat;
  } vec_t;

  vec_t vecs[10];
  int   rr_order[5];

  initial begin
    int t0, t1, g, k, seen;

    vecs[0] = '{0, 8'h05, 8'h03, ADD, 16'h0008, 3};
    vecs[1] = '{1, 8'h10, 8'h01, SUB, 16'h000F, 3};
    vecs[2] = '{2, 8'hF0, 8'h3C, AND, 16'h0030, 3};
    vecs[3] = '{3, 8'hAA, 8'h55, XOR, 16'h00FF, 3};
    vecs[4] = '{0, 8'h0F, 8'h00, NOT, 16'h00F0, 3};
    vecs[5] = '{1, 8'hFF, 8'h00, INC, 16'h0100, 5};
    vecs[6] = '{2, 8'h12, 8'h34, NOP, 16'h0000, 3};
    vecs[7] = '{3, 8'hFF, 8'hFF, ADD, 16'h01FE, 3};
    vecs[8] = '{0, 8'h00, 8'h01, SUB, 16'hFFFF, 3};
    vecs[9] = '{1, 8'hFF, 8'hFF, MUL, 16'hFE01, 5};
    rr_order = '{0, 1, 2, 3, 0};

    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_a[i]  = '0;
      req_b[i]  = '0;
      req_op[i] = NOP;
    end

    // Reset values, sampled while reset is still asserted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'(NOP));
    @(posedge clk); #1 reset = 1'b0;

    // Table-driven single requests.
    for (int v = 0; v < 10; v++)
      run_req($sformatf("vec%0d", v), vecs[v].id, vecs[v].a, vecs[v].b,
              vecs[v].op, vecs[v].exp, 1'b0, vecs[v].lat);

    // Round robin with all four requesters pending; req0 re-requests.
    reset_dut();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      req_a[i]  = operand_t'(i);
      req_b[i]  = 8'hF0;
      req_op[i] = XOR;
    end
    req_valid = '1;
    for (int r = 0; r < 5; r++) begin
      g = -1;
      k = 0;
      while (k < 50 && g < 0) begin
        @(negedge clk);
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        k++;
      end
      chk($sformatf("rr_grant%0d", r), 32'(g), 32'(rr_order[r]));
      @(posedge clk); #1;
      if (g >= 0) req_valid[g] = 1'b0;
      wait_rsp(t1);
      chk($sformatf("rr_id%0d", r), 32'(rsp_id), 32'(rr_order[r]));
      chk($sformatf("rr_result%0d", r), 32'(rsp_result), 32'(16'h00F0 ^ 16'(rr_order[r])));
      if (r == 0) begin
        @(posedge clk); #1;
        req_valid[0] = 1'b1;
      end
    end

    // MUL: operands held while busy, competing requester kept waiting.
    reset_dut();
    @(posedge clk); #1;
    req_a[0] = 8'h10; req_b[0] = 8'h10; req_op[0] = MUL;
    req_a[1] = 8'h07; req_b[1] = 8'h08; req_op[1] = ADD;
    req_valid = 4'b0011;
    wait_ready(0, t0);
    chk("mul_req1_not_ready", 32'(req_ready[1]), 32'd0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    k = 0;
    t1 = -1;
    while (k < 50) begin
      @(negedge clk);
      if (rsp_valid) begin
        t1 = cyc;
        break;
      end
      chk("mul_start", 32'(alu_start), 32'd1);
      chk("mul_alu_a", 32'(alu_a), 32'h10);
      chk("mul_alu_b", 32'(alu_b), 32'h10);
      chk("mul_alu_op", 32'(alu_op), 32'(MUL));
      chk("mul_no_accept", 32'(req_ready), 32'd0);
      k++;
    end
    chk("mul_rsp_seen", 32'(t1 >= 0), 32'd1);
    chk("mul_id", 32'(rsp_id), 32'd0);
    chk("mul_result", 32'(rsp_result), 32'h0100);
    chk("mul_latency", 32'(t1 - t0), 32'd5);
    wait_ready(1, t0);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_rsp(t1);
    chk("mul_next_id", 32'(rsp_id), 32'd1);
    chk("mul_next_result", 32'(rsp_result), 32'h000F);

    // Backpressure: response held for 5 cycles, nobody accepted meanwhile.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_a[2] = 8'h02; req_b[2] = 8'h03; req_op[2] = ADD;
    req_a[3] = 8'h0F; req_b[3] = 8'hFF; req_op[3] = AND;
    req_valid = 4'b1100;
    wait_ready(2, t0);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    wait_rsp(t1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_id", 32'(rsp_id), 32'd2);
      chk("bp_result", 32'(rsp_result), 32'h0005);
      chk("bp_no_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_ready(3, t0);
    chk("bp_released", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    wait_rsp(t1);
    chk("bp_next_id", 32'(rsp_id), 32'd3);
    chk("bp_next_result", 32'(rsp_result), 32'h000F);

    // Reset during a MUL: no response, next request works normally.
    reset_dut();
    @(posedge clk); #1;
    req_a[0] = 8'h10; req_b[0] = 8'h10; req_op[0] = MUL;
    req_valid[0] = 1'b1;
    wait_ready(0, t0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("rstb_busy", 32'(alu_start), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rstb_start_drop", 32'(alu_start), 32'd0);
    chk("rstb_no_rsp", 32'(rsp_valid), 32'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("rstb_no_late_rsp", 32'(seen), 32'd0);
    run_req("rstb_add", 0, 8'h01, 8'h01, ADD, 16'h0002, 1'b0, 3);

`ifdef ALU_ARB_TIMEOUT_EN
    reset_dut();
    stall = 1'b1;
    run_req("timeout", 2, 8'h01, 8'h02, ADD, 16'h0000, 1'b1, 17);
    stall = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, want finish", cyc);
    $fatal(1);
  end

endmodule
